// File: rtl/irq_sequencer.sv
// Interrupt sequencer for the 5-stage core: edge-detects key/Ethernet lines, waits for a
// safe decode slot, redirects fetch into the ISR and back to the saved PC on rti.
module irq_sequencer #(
    parameter logic [31:0] KEY_VECTOR = 32'h0000_0100,
    parameter logic [31:0] ETH_VECTOR = 32'h0000_0200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        interrupt_key,
    input  logic        interrupt_eth,
    input  logic [31:0] key_data,
    input  logic [31:0] eth_data,
    input  logic        dec_valid,
    input  logic [31:0] pc_dec,
    input  logic        branch_ex,
    input  logic        stall,
    input  logic        rti,
    input  logic        rsi,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic        in_isr,
    output logic [1:0]  pending,
    output logic [1:0]  overrun,
    output logic [31:0] rdi_data,
    output logic [31:0] epc
);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ENTER, S_ISR, S_RETURN} state_t;

    state_t      state_q, state_d;
    logic [1:0]  line_q, line_d;
    logic [1:0]  line_prev_q, line_prev_d;
    logic [31:0] key_smp_q, key_smp_d;
    logic [31:0] eth_smp_q, eth_smp_d;
    logic [31:0] key_pay_q, key_pay_d;
    logic [31:0] eth_pay_q, eth_pay_d;
    logic [1:0]  pending_q, pending_d;
    logic [1:0]  overrun_q, overrun_d;
    logic        ie_q, ie_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] rdi_data_q, rdi_data_d;
    logic        redirect_q, redirect_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic        in_isr_q, in_isr_d;
    logic [1:0]  rise;
    logic [1:0]  clr;
    logic        safe;

    always_comb begin
        state_d       = state_q;
        line_d        = {interrupt_eth, interrupt_key};
        line_prev_d   = line_q;
        key_smp_d     = key_data;
        eth_smp_d     = eth_data;
        key_pay_d     = key_pay_q;
        eth_pay_d     = eth_pay_q;
        epc_d         = epc_q;
        rdi_data_d    = rdi_data_q;
        ie_d          = ie_q | (rsi & ~stall);
        rise          = line_q & ~line_prev_q;
        clr           = 2'b00;
        safe          = dec_valid & ~branch_ex & ~stall;

        case (state_q)
            S_IDLE:   if ((|pending_q) && ie_q) state_d = S_WAIT;
            S_WAIT: begin
                if (safe) begin
                    state_d = S_ENTER;
                    epc_d   = pc_dec;
                    if (pending_q[1]) begin
                        clr        = 2'b10;
                        rdi_data_d = eth_pay_q;
                    end else begin
                        clr        = 2'b01;
                        rdi_data_d = key_pay_q;
                    end
                end
            end
            S_ENTER:  state_d = S_ISR;
            S_ISR:    if (rti && !stall) state_d = S_RETURN;
            S_RETURN: state_d = (|pending_q) ? S_WAIT : S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        // A new edge on the source being entered re-arms it rather than counting as overrun
        pending_d = (pending_q & ~clr) | rise;
        overrun_d = (overrun_q & ~clr) | (rise & pending_q & ~clr);
        if (rise[0] && (!pending_q[0] || clr[0])) key_pay_d = key_smp_q;
        if (rise[1] && (!pending_q[1] || clr[1])) eth_pay_d = eth_smp_q;

        redirect_d    = (state_d == S_ENTER) || (state_d == S_RETURN);
        in_isr_d      = (state_d == S_ISR);
        redirect_pc_d = 32'h0;
        if (state_d == S_ENTER)       redirect_pc_d = pending_q[1] ? ETH_VECTOR : KEY_VECTOR;
        else if (state_d == S_RETURN) redirect_pc_d = epc_q;
        if (state_d == S_IDLE) rdi_data_d = 32'h0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            line_q        <= 2'b00;
            line_prev_q   <= 2'b00;
            key_smp_q     <= 32'h0;
            eth_smp_q     <= 32'h0;
            key_pay_q     <= 32'h0;
            eth_pay_q     <= 32'h0;
            pending_q     <= 2'b00;
            overrun_q     <= 2'b00;
            ie_q          <= 1'b0;
            epc_q         <= 32'h0;
            rdi_data_q    <= 32'h0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= 32'h0;
            in_isr_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            line_q        <= line_d;
            line_prev_q   <= line_prev_d;
            key_smp_q     <= key_smp_d;
            eth_smp_q     <= eth_smp_d;
            key_pay_q     <= key_pay_d;
            eth_pay_q     <= eth_pay_d;
            pending_q     <= pending_d;
            overrun_q     <= overrun_d;
            ie_q          <= ie_d;
            epc_q         <= epc_d;
            rdi_data_q    <= rdi_data_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            in_isr_q      <= in_isr_d;
        end
    end

    assign redirect    = redirect_q;
    assign flush       = redirect_q;
    assign redirect_pc = redirect_pc_q;
    assign in_isr      = in_isr_q;
    assign pending     = pending_q;
    assign overrun     = overrun_q;
    assign rdi_data    = rdi_data_q;
    assign epc         = epc_q;

endmodule

// File: tb/tb_irq_sequencer.sv
// Directed bench for irq_sequencer: a per-cycle vector table for the basic entry/return
// flow, then hand-written sequences for the multi-cycle corner cases.
module tb_irq_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        interrupt_key, interrupt_eth;
    logic [31:0] key_data, eth_data;
    logic        dec_valid;
    logic [31:0] pc_dec;
    logic        branch_ex, stall, rti, rsi;
    logic        redirect, flush, in_isr;
    logic [31:0] redirect_pc, rdi_data, epc;
    logic [1:0]  pending, overrun;

    int total = 0;
    int bad   = 0;

    irq_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .interrupt_key(interrupt_key), .interrupt_eth(interrupt_eth),
        .key_data(key_data), .eth_data(eth_data),
        .dec_valid(dec_valid), .pc_dec(pc_dec),
        .branch_ex(branch_ex), .stall(stall), .rti(rti), .rsi(rsi),
        .redirect(redirect), .redirect_pc(redirect_pc), .flush(flush),
        .in_isr(in_isr), .pending(pending), .overrun(overrun),
        .rdi_data(rdi_data), .epc(epc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        key;
        logic [31:0] kdata;
        logic        rti;
        logic        stall;
        logic        rsi;
        logic [31:0] pc;
        logic        e_red;
        logic [31:0] e_rpc;
        logic        e_isr;
        logic [1:0]  e_pend;
        logic [31:0] e_rdi;
        logic [31:0] e_epc;
    } vec_t;

    vec_t vt[10];

    function automatic vec_t mk(input logic k, input logic [31:0] kd, input logic r,
                                input logic s, input logic e, input logic [31:0] p,
                                input logic ered, input logic [31:0] erpc, input logic eisr,
                                input logic [1:0] epend, input logic [31:0] erdi,
                                input logic [31:0] eepc);
        vec_t v;
        v.key = k; v.kdata = kd; v.rti = r; v.stall = s; v.rsi = e; v.pc = p;
        v.e_red = ered; v.e_rpc = erpc; v.e_isr = eisr; v.e_pend = epend;
        v.e_rdi = erdi; v.e_epc = eepc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_redir(input int maxc, output int n);
        n = -1;
        for (int i = 1; i <= maxc; i++) begin
            tick();
            if (redirect) begin
                n = i;
                break;
            end
        end
    endtask

    // Called with ENTER visible: step into ISR, issue rti, expect the return redirect.
    task automatic do_rti(input logic [31:0] exp_pc);
        tick();
        chk("isr_active", 32'(in_isr), 32'd1);
        rti = 1'b1;
        tick();
        rti = 1'b0;
        chk("ret_redirect", 32'(redirect), 32'd1);
        chk("ret_flush", 32'(flush), 32'd1);
        chk("ret_pc", redirect_pc, exp_pc);
        chk("ret_in_isr", 32'(in_isr), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        int n;
        int cnt;
        rst_n = 1'b0;
        interrupt_key = 1'b0; interrupt_eth = 1'b0;
        key_data = '0; eth_data = '0;
        dec_valid = 1'b1; pc_dec = 32'h40;
        branch_ex = 1'b0; stall = 1'b0; rti = 1'b0; rsi = 1'b0;

        //          key kdata          rti st rsi pc      | red rpc     isr pend rdi            epc
        vt[0] = mk(0, 32'h0,          0, 0, 1, 32'h40,  0, 32'h0,   0, 2'b00, 32'h0,         32'h0);
        vt[1] = mk(1, 32'hCAFE_0001,  0, 0, 0, 32'h40,  0, 32'h0,   0, 2'b00, 32'h0,         32'h0);
        vt[2] = mk(1, 32'hCAFE_0001,  0, 0, 0, 32'h40,  0, 32'h0,   0, 2'b01, 32'h0,         32'h0);
        vt[3] = mk(1, 32'hCAFE_0001,  0, 0, 0, 32'h40,  0, 32'h0,   0, 2'b01, 32'h0,         32'h0);
        vt[4] = mk(1, 32'hCAFE_0001,  0, 0, 0, 32'h40,  1, 32'h100, 0, 2'b00, 32'hCAFE_0001, 32'h40);
        vt[5] = mk(1, 32'hCAFE_0001,  0, 0, 0, 32'h100, 0, 32'h0,   1, 2'b00, 32'hCAFE_0001, 32'h40);
        vt[6] = mk(1, 32'hCAFE_0001,  1, 1, 0, 32'h100, 0, 32'h0,   1, 2'b00, 32'hCAFE_0001, 32'h40);
        vt[7] = mk(1, 32'hCAFE_0001,  1, 0, 0, 32'h100, 1, 32'h40,  0, 2'b00, 32'hCAFE_0001, 32'h40);
        vt[8] = mk(1, 32'hCAFE_0001,  0, 0, 0, 32'h40,  0, 32'h0,   0, 2'b00, 32'h0,         32'h40);
        vt[9] = mk(0, 32'hCAFE_0001,  1, 0, 0, 32'h40,  0, 32'h0,   0, 2'b00, 32'h0,         32'h40);

        tick();
        tick();
        chk("rst_redirect", 32'(redirect), 32'd0);
        chk("rst_rpc", redirect_pc, 32'h0);
        chk("rst_in_isr", 32'(in_isr), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_rdi", rdi_data, 32'h0);
        chk("rst_epc", epc, 32'h0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            interrupt_key = vt[i].key;
            key_data      = vt[i].kdata;
            rti           = vt[i].rti;
            stall         = vt[i].stall;
            rsi           = vt[i].rsi;
            pc_dec        = vt[i].pc;
            tick();
            chk($sformatf("v%0d_redirect", i), 32'(redirect), 32'(vt[i].e_red));
            chk($sformatf("v%0d_flush", i), 32'(flush), 32'(vt[i].e_red));
            chk($sformatf("v%0d_rpc", i), redirect_pc, vt[i].e_rpc);
            chk($sformatf("v%0d_in_isr", i), 32'(in_isr), 32'(vt[i].e_isr));
            chk($sformatf("v%0d_pending", i), 32'(pending), 32'(vt[i].e_pend));
            chk($sformatf("v%0d_rdi", i), rdi_data, vt[i].e_rdi);
            chk($sformatf("v%0d_epc", i), epc, vt[i].e_epc);
        end
        rti = 1'b0; stall = 1'b0; rsi = 1'b0; interrupt_key = 1'b0;

        // Disabled: request stays pending until rsi
        do_reset();
        interrupt_key = 1'b1; key_data = 32'h55; pc_dec = 32'h60;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (redirect) cnt++;
        end
        chk("dis_no_redirect", 32'(cnt), 32'd0);
        chk("dis_pending", 32'(pending), 32'd1);
        rsi = 1'b1;
        tick();
        rsi = 1'b0;
        wait_redir(6, n);
        chk("dis_entry_lat", 32'(n), 32'd2);
        chk("dis_entry_pc", redirect_pc, 32'h100);
        chk("dis_rdi", rdi_data, 32'h55);
        chk("dis_epc", epc, 32'h60);
        do_rti(32'h60);

        // Simultaneous edges: eth first, then key re-entry after a gap
        interrupt_key = 1'b0; interrupt_eth = 1'b0;
        tick(); tick();
        interrupt_key = 1'b1; interrupt_eth = 1'b1;
        key_data = 32'h1111; eth_data = 32'h2222; pc_dec = 32'h80;
        wait_redir(8, n);
        chk("sim_entry_lat", 32'(n), 32'd4);
        chk("sim_entry_pc", redirect_pc, 32'h200);
        chk("sim_rdi", rdi_data, 32'h2222);
        chk("sim_epc", epc, 32'h80);
        chk("sim_pending", 32'(pending), 32'd1);
        pc_dec = 32'h300;
        do_rti(32'h80);
        pc_dec = 32'h84;
        tick();
        chk("sim_gap", 32'(redirect), 32'd0);
        tick();
        chk("sim_reentry", 32'(redirect), 32'd1);
        chk("sim_reentry_pc", redirect_pc, 32'h100);
        chk("sim_reentry_epc", epc, 32'h84);
        chk("sim_reentry_rdi", rdi_data, 32'h1111);
        do_rti(32'h84);

        // Blocking: branch, stall and bubble all hold WAIT
        interrupt_key = 1'b0; interrupt_eth = 1'b0;
        tick(); tick(); tick();
        interrupt_key = 1'b1; key_data = 32'h77; branch_ex = 1'b1; pc_dec = 32'h10;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (redirect) cnt++;
        end
        branch_ex = 1'b0; stall = 1'b1; pc_dec = 32'h14;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (redirect) cnt++;
        end
        stall = 1'b0; dec_valid = 1'b0; pc_dec = 32'h18;
        tick();
        if (redirect) cnt++;
        chk("blk_no_redirect", 32'(cnt), 32'd0);
        dec_valid = 1'b1; pc_dec = 32'h1C;
        tick();
        chk("blk_redirect", 32'(redirect), 32'd1);
        chk("blk_rpc", redirect_pc, 32'h100);
        chk("blk_epc", epc, 32'h1C);
        chk("blk_rdi", rdi_data, 32'h77);
        do_rti(32'h1C);

        // Overrun: second edge while pending keeps the first payload
        interrupt_key = 1'b0;
        tick(); tick(); tick();
        dec_valid = 1'b0; pc_dec = 32'h30;
        interrupt_key = 1'b1; key_data = 32'h11;
        tick(); tick();
        chk("ovr_pending1", 32'(pending), 32'd1);
        chk("ovr_none_yet", 32'(overrun), 32'd0);
        interrupt_key = 1'b0;
        tick();
        interrupt_key = 1'b1; key_data = 32'h22;
        tick(); tick();
        chk("ovr_set", 32'(overrun), 32'd1);
        chk("ovr_pending2", 32'(pending), 32'd1);
        dec_valid = 1'b1;
        wait_redir(4, n);
        chk("ovr_entry_lat", 32'(n), 32'd1);
        chk("ovr_rdi", rdi_data, 32'h11);
        chk("ovr_cleared", 32'(overrun), 32'd0);
        chk("ovr_pending_clr", 32'(pending), 32'd0);
        do_rti(32'h30);

        // Asynchronous reset in the middle of an ISR
        interrupt_key = 1'b0;
        tick(); tick(); tick();
        interrupt_key = 1'b1; key_data = 32'h99; pc_dec = 32'h50;
        wait_redir(8, n);
        chk("ar_entry_lat", 32'(n), 32'd4);
        tick();
        chk("ar_in_isr", 32'(in_isr), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_in_isr0", 32'(in_isr), 32'd0);
        chk("ar_redirect0", 32'(redirect), 32'd0);
        chk("ar_rdi0", rdi_data, 32'h0);
        chk("ar_epc0", epc, 32'h0);
        chk("ar_pending0", 32'(pending), 32'd0);
        interrupt_key = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        interrupt_key = 1'b1; key_data = 32'hAB;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (redirect) cnt++;
        end
        chk("ar_no_redirect", 32'(cnt), 32'd0);
        chk("ar_pending_ie0", 32'(pending), 32'd1);
        chk("ar_in_isr_after", 32'(in_isr), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
